// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader that drives the write side of the instruction
//   memory. It takes a little-endian byte stream made of a 32-bit word-count
//   header followed by the program words. It assembles each group of four bytes
//   into a 32-bit word and writes that word through a single-cycle write port.
//   The CPU is held in reset until the whole image has been written.
//
// Ports
//   SYS_clk       in   1      clock, rising edge
//   SYS_reset_n   in   1      synchronous active-low reset
//   start         in   1      restart pulse, honoured only in DONE or ERR
//   in_valid      in   1      byte on in_data is valid
//   in_data       in   8      stream byte
//   in_ready      out  1      byte accepted this cycle when in_valid is high
//   mem_we        out  1      instruction memory write enable, one pulse per word
//   mem_addr      out  32     byte address of the write (BASE_ADDR + 4*idx)
//   mem_wdata     out  32     assembled instruction word
//   cpu_hold      out  1      keep the CPU in reset (loading or error)
//   done          out  1      image fully written
//   error         out  1      header word count exceeded DEPTH_WORDS
//   words_loaded  out  CNT_W  number of words written so far
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      DEPTH_L = 32'(DEPTH_WORDS);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       byte_cnt_r;
  logic [CNT_W-1:0] idx_r;
  logic [CNT_W-1:0] word_count_r;
  logic [23:0]      shift_r;      // bytes 0..2 of the word being collected
  logic [31:0]      wdata_r;
  logic [31:0]      addr_r;

  logic             accept_s;
  logic             last_byte_s;
  logic [31:0]      word_s;       // complete word once the 4th byte arrives
  logic [CNT_W-1:0] idx_inc_s;
  logic [31:0]      addr_nxt_s;

  // Handshake decode and word/address arithmetic shared by FSM and datapath
  always_comb begin
    accept_s    = in_valid && in_ready;
    last_byte_s = accept_s && (byte_cnt_r == 2'd3);
    word_s      = {in_data, shift_r};
    idx_inc_s   = idx_r + CNT_ONE;
    addr_nxt_s  = BASE_ADDR + {{(30-CNT_W){1'b0}}, idx_r, 2'b00};
  end

  // State register
  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset_n) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HDR: begin
        // The full 32-bit header is compared, so any nonzero bits above
        // CNT_W also push the count past DEPTH_WORDS and land in ERR.
        if (last_byte_s) begin
          if (word_s == 32'h0000_0000) begin
            state_nxt_s = ST_DONE;
          end else if (word_s > DEPTH_L) begin
            state_nxt_s = ST_ERR;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (last_byte_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (idx_inc_s == word_count_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_DONE, ST_ERR: begin
        if (start) begin
          state_nxt_s = ST_HDR;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_HDR;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    cpu_hold     = 1'b1;
    mem_addr     = addr_r;
    mem_wdata    = wdata_r;
    words_loaded = idx_r;
    case (state_r)
      ST_HDR:   in_ready = 1'b1;
      ST_DATA:  in_ready = 1'b1;
      ST_WRITE: mem_we   = 1'b1;
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ST_ERR:   error    = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  // Byte collection, header capture, write latching and word index
  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset_n) begin
      byte_cnt_r   <= 2'd0;
      idx_r        <= {CNT_W{1'b0}};
      word_count_r <= {CNT_W{1'b0}};
      shift_r      <= 24'h00_0000;
      wdata_r      <= 32'h0000_0000;
      addr_r       <= BASE_ADDR;
    end else begin
      case (state_r)
        ST_HDR, ST_DATA: begin
          if (accept_s) begin
            case (byte_cnt_r)
              2'd0:    shift_r[7:0]   <= in_data;
              2'd1:    shift_r[15:8]  <= in_data;
              2'd2:    shift_r[23:16] <= in_data;
              default: shift_r        <= 24'h00_0000;
            endcase
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (last_byte_s) begin
              if (state_r == ST_HDR) begin
                word_count_r <= word_s[CNT_W-1:0];
              end else begin
                // Address is captured here so it is stable for the whole
                // WRITE cycle and then holds as the last written address.
                wdata_r <= word_s;
                addr_r  <= addr_nxt_s;
              end
            end
          end
        end
        ST_WRITE: begin
          idx_r <= idx_inc_s;
        end
        ST_DONE, ST_ERR: begin
          if (start) begin
            byte_cnt_r   <= 2'd0;
            idx_r        <= {CNT_W{1'b0}};
            word_count_r <= {CNT_W{1'b0}};
            shift_r      <= 24'h00_0000;
            wdata_r      <= 32'h0000_0000;
            addr_r       <= BASE_ADDR;
          end
        end
        default: begin
          byte_cnt_r <= 2'd0;
        end
      endcase
    end
  end

endmodule
